// File: rtl/engine_filter_cond_result_buffer_pkg.sv
// Shared types for the filter-condition result buffer: packet meta/data, FIFO entry, FSM encoding.
// Pure declarations; no timing or flow control lives here.
package engine_filter_cond_result_buffer_pkg;

    typedef struct packed {
        logic [7:0] src_id;
        logic [7:0] tag;
    } MemoryPacketMeta;

    typedef logic [31:0] MemoryPacketData;

    typedef struct packed {
        MemoryPacketMeta meta;
        MemoryPacketData data;
        logic            flag;
    } FilterCondResultEntry;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } engine_filter_cond_result_buffer_state;

    // Head value presented while nothing valid is queued (flag idles high).
    localparam FilterCondResultEntry FCR_ENTRY_RST = '{meta: '0, data: '0, flag: 1'b1};

    function automatic logic fcr_keep(input logic drop_on_false, input logic flag);
        return !(drop_on_false && !flag);
    endfunction

endpackage

// File: rtl/engine_filter_cond_result_buffer_if.sv
// Output stream of the result buffer toward the engine output arbiter.
// Valid/ready: a transfer happens on an edge with out_valid & out_ready.
interface engine_filter_cond_result_buffer_if;
    import engine_filter_cond_result_buffer_pkg::*;

    logic            out_valid;
    logic            out_ready;
    MemoryPacketMeta out_meta;
    MemoryPacketData out_data;
    logic            out_flag;

    modport master (output out_valid, out_meta, out_data, out_flag, input out_ready);
    modport slave  (input out_valid, out_meta, out_data, out_flag, output out_ready);
endinterface

// File: rtl/engine_filter_cond_result_fifo.sv
// Synchronous FIFO of result entries with a registered head; a write shows at the head one edge later.
// Full write with a simultaneous read succeeds; a full write without a read is ignored (caller flags it).
module engine_filter_cond_result_fifo
    import engine_filter_cond_result_buffer_pkg::*;
#(
    parameter int  FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 clear,
    input  logic                 wr_vld,
    input  FilterCondResultEntry wr_dat,
    input  logic                 rd_rdy,
    output FilterCondResultEntry head_dat,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          count
);

    FilterCondResultEntry mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] wr_ptr_nxt, rd_ptr_nxt;
    logic        rd_ok, wr_ok;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign rd_ok      = rd_rdy && !empty;
    assign wr_ok      = wr_vld && (!full || rd_ok);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd_ok);
    assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_ok);

    always_ff @(posedge ap_clk) begin
        if (ap_rst_n && !clear && wr_ok)
            mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

    // The head register tracks the slot rd_ptr will point at after this edge;
    // a write landing in that slot is forwarded so the head never goes stale.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_dat <= FCR_ENTRY_RST;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (wr_ok && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
                head_dat <= wr_dat;
            else
                head_dat <= mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/engine_filter_cond_result_buffer.sv
// Realigns issue metadata with the fixed-latency kernel result, drops/forwards by flag, queues survivors.
// Latency KERNEL_LATENCY+1 from in_valid to out_valid; almost_full throttles issue, out_ready drains the FIFO.
module engine_filter_cond_result_buffer
    import engine_filter_cond_result_buffer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int KERNEL_LATENCY = 2
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    input  logic                                clear,
    input  logic                                config_params_valid,
    input  logic                                drop_on_false,
    input  logic                                in_valid,
    input  MemoryPacketMeta                     in_meta,
    input  logic                                kernel_result_flag,
    input  MemoryPacketData                     kernel_result_data,
    engine_filter_cond_result_buffer_if.master  out_bus,
    output logic                                almost_full,
    output logic                                overflow_error,
    output logic [31:0]                         passed_count,
    output logic [31:0]                         dropped_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] AF_THRESH = (AW+1)'(FIFO_DEPTH - KERNEL_LATENCY - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    logic [1:0] state_q, state_nxt;

    logic [KERNEL_LATENCY-1:0] dl_vld;
    MemoryPacketMeta           dl_meta [KERNEL_LATENCY];
    logic                      shift_en;

    logic                 tail_vld, keep, wr_req, rd_ok, ovf_evt;
    FilterCondResultEntry wr_dat, head_dat;
    logic                 fifo_full, fifo_empty;
    logic [AW:0]          fifo_count;

    always_comb begin
        state_nxt = state_q;
        if (clear) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: if (config_params_valid) state_nxt = ST_RUN;
                // Leave RUN only once every in-flight kernel sample has been resolved.
                ST_RUN:  if (!config_params_valid && (dl_vld == '0)) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_nxt;
    end

    assign shift_en = (state_q == ST_RUN);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || clear) begin
            dl_vld <= '0;
        end else if (shift_en) begin
            for (int i = KERNEL_LATENCY - 1; i > 0; i--)
                dl_vld[i] <= dl_vld[i-1];
            dl_vld[0] <= in_valid && config_params_valid;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (shift_en) begin
            for (int i = KERNEL_LATENCY - 1; i > 0; i--)
                dl_meta[i] <= dl_meta[i-1];
            dl_meta[0] <= in_meta;
        end
    end

    assign tail_vld = dl_vld[KERNEL_LATENCY-1];
    assign keep     = fcr_keep(drop_on_false, kernel_result_flag);
    assign wr_req   = tail_vld && keep;
    assign wr_dat   = '{meta: dl_meta[KERNEL_LATENCY-1], data: kernel_result_data, flag: kernel_result_flag};
    assign rd_ok    = out_bus.out_valid && out_bus.out_ready;
    assign ovf_evt  = wr_req && fifo_full && !rd_ok;

    engine_filter_cond_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clear    (clear),
        .wr_vld   (wr_req),
        .wr_dat   (wr_dat),
        .rd_rdy   (out_bus.out_ready),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign out_bus.out_valid = !fifo_empty;
    assign out_bus.out_meta  = head_dat.meta;
    assign out_bus.out_data  = head_dat.data;
    assign out_bus.out_flag  = head_dat.flag;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || clear) begin
            almost_full    <= 1'b0;
            overflow_error <= 1'b0;
            passed_count   <= '0;
            dropped_count  <= '0;
        end else begin
            almost_full <= (fifo_count >= AF_THRESH);
            if (ovf_evt)
                overflow_error <= 1'b1;
            if (tail_vld && !keep)
                dropped_count <= dropped_count + 32'd1;
            if (wr_req && !ovf_evt)
                passed_count <= passed_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_engine_filter_cond_result_buffer.sv
// Directed bench for engine_filter_cond_result_buffer with a 2-cycle kernel model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_engine_filter_cond_result_buffer;
    import engine_filter_cond_result_buffer_pkg::*;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            config_params_valid = 1'b1;
    logic            drop_on_false = 1'b0;
    logic            in_valid = 1'b0;
    MemoryPacketMeta in_meta = '0;
    logic            kernel_result_flag = 1'b0;
    MemoryPacketData kernel_result_data = '0;
    logic            almost_full, overflow_error;
    logic [31:0]     passed_count, dropped_count;

    logic            kin_flag = 1'b0, k1_flag = 1'b0;
    MemoryPacketData kin_data = '0, k1_data = '0;

    int tests_run = 0;
    int tests_failed = 0;

    engine_filter_cond_result_buffer_if bus();

    engine_filter_cond_result_buffer #(
        .FIFO_DEPTH     (16),
        .KERNEL_LATENCY (2)
    ) dut (
        .ap_clk              (ap_clk),
        .ap_rst_n            (ap_rst_n),
        .clear               (clear),
        .config_params_valid (config_params_valid),
        .drop_on_false       (drop_on_false),
        .in_valid            (in_valid),
        .in_meta             (in_meta),
        .kernel_result_flag  (kernel_result_flag),
        .kernel_result_data  (kernel_result_data),
        .out_bus             (bus),
        .almost_full         (almost_full),
        .overflow_error      (overflow_error),
        .passed_count        (passed_count),
        .dropped_count       (dropped_count)
    );

    always #5 ap_clk = ~ap_clk;

    // One clock edge; the kernel model shifts its 2-stage pipe in step with the DUT.
    task automatic step();
        @(posedge ap_clk);
        #1;
        kernel_result_flag = k1_flag;
        kernel_result_data = k1_data;
        k1_flag = kin_flag;
        k1_data = kin_data;
    endtask

    task automatic drive(input logic v, input logic [15:0] m, input logic f);
        in_valid = v;
        in_meta  = MemoryPacketMeta'(m);
        kin_data = {16'hDA7A, m};
        kin_flag = f;
    endtask

    task automatic do_clear();
        drive(1'b0, 16'h0, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (3) step();
    endtask

    task automatic issue_run(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 16'(i), 1'b1);
            step();
        end
        drive(1'b0, 16'h0, 1'b0);
    endtask

    // Eight issues: first one dropped, five queued, two still in the delay line.
    task automatic prep_midstream(input logic [15:0] base);
        do_clear();
        drop_on_false = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b1, base, 1'b0);
        step();
        issue_run(base + 16'd1, 7);
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) step();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        tests_run++; if (bus.out_meta !== 16'h0) begin tests_failed++; $display("FAIL reset_out_meta: got %h expected 0000", bus.out_meta); end
        tests_run++; if (bus.out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        tests_run++; if (bus.out_flag !== 1'b1) begin tests_failed++; $display("FAIL reset_out_flag: got %b expected 1", bus.out_flag); end
        tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
        tests_run++; if (overflow_error !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow_error); end
        tests_run++; if (passed_count !== 32'd0) begin tests_failed++; $display("FAIL reset_passed: got %0d expected 0", passed_count); end
        tests_run++; if (dropped_count !== 32'd0) begin tests_failed++; $display("FAIL reset_dropped: got %0d expected 0", dropped_count); end
        ap_rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_single();
        drop_on_false = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h0005, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0);
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early1: out_valid %b expected 0", bus.out_valid); end
        step();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early2: out_valid %b expected 0", bus.out_valid); end
        step();
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_meta !== 16'h0005) begin tests_failed++; $display("FAIL single_out: valid=%b meta=%h expected valid=1 meta=0005", bus.out_valid, bus.out_meta); end
        tests_run++; if (bus.out_data !== 32'hDA7A_0005 || bus.out_flag !== 1'b1) begin tests_failed++; $display("FAIL single_data: data=%h flag=%b expected da7a0005/1", bus.out_data, bus.out_flag); end
        tests_run++; if (passed_count !== 32'd1) begin tests_failed++; $display("FAIL single_passed: got %0d expected 1", passed_count); end
        step();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_pop: out_valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back_drop();
        logic [3:0] flags;
        flags = 4'b0101;
        drop_on_false = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0011 + 16'(i), flags[i]);
            step();
        end
        drive(1'b0, 16'h0, 1'b0);
        repeat (3) step();
        tests_run++; if (passed_count !== 32'd3) begin tests_failed++; $display("FAIL drop_passed: got %0d expected 3", passed_count); end
        tests_run++; if (dropped_count !== 32'd2) begin tests_failed++; $display("FAIL drop_dropped: got %0d expected 2", dropped_count); end
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_meta !== 16'h0011) begin tests_failed++; $display("FAIL drop_head0: valid=%b meta=%h expected 1/0011", bus.out_valid, bus.out_meta); end
        step();
        tests_run++; if (bus.out_meta !== 16'h0011) begin tests_failed++; $display("FAIL drop_hold: meta=%h expected 0011", bus.out_meta); end
        bus.out_ready = 1'b1;
        step();
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_meta !== 16'h0013) begin tests_failed++; $display("FAIL drop_head1: valid=%b meta=%h expected 1/0013", bus.out_valid, bus.out_meta); end
        step();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_empty: out_valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_almost_full();
        int issued, af_first;
        do_clear();
        drop_on_false = 1'b0;
        bus.out_ready = 1'b0;
        issued = 0;
        af_first = -1;
        for (int k = 0; k < 40; k++) begin
            if (almost_full && af_first < 0) af_first = k;
            if (!almost_full) begin
                drive(1'b1, 16'h0100 + 16'(issued), 1'b1);
                issued++;
            end else begin
                drive(1'b0, 16'h0, 1'b0);
            end
            step();
        end
        drive(1'b0, 16'h0, 1'b0);
        tests_run++; if (issued !== 16) begin tests_failed++; $display("FAIL af_issued: got %0d expected 16", issued); end
        tests_run++; if (af_first !== 16) begin tests_failed++; $display("FAIL af_rise_cycle: got %0d expected 16", af_first); end
        tests_run++; if (overflow_error !== 1'b0) begin tests_failed++; $display("FAIL af_no_overflow: got %b expected 0", overflow_error); end
        tests_run++; if (passed_count !== 32'd16) begin tests_failed++; $display("FAIL af_passed: got %0d expected 16", passed_count); end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tests_run++; if (bus.out_valid !== 1'b1 || bus.out_meta !== 16'h0100 + 16'(j)) begin tests_failed++; $display("FAIL af_drain[%0d]: valid=%b meta=%h expected 1/%h", j, bus.out_valid, bus.out_meta, 16'h0100 + 16'(j)); end
            step();
        end
        step();
        tests_run++; if (bus.out_valid !== 1'b0 || almost_full !== 1'b0) begin tests_failed++; $display("FAIL af_drained: valid=%b af=%b expected 0/0", bus.out_valid, almost_full); end
    endtask

    task automatic test_overflow();
        do_clear();
        drop_on_false = 1'b0;
        bus.out_ready = 1'b0;
        issue_run(16'h0200, 17);
        repeat (4) step();
        tests_run++; if (overflow_error !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b expected 1", overflow_error); end
        tests_run++; if (passed_count !== 32'd16) begin tests_failed++; $display("FAIL ovf_passed: got %0d expected 16", passed_count); end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tests_run++; if (bus.out_valid !== 1'b1 || bus.out_meta !== 16'h0200 + 16'(j)) begin tests_failed++; $display("FAIL ovf_drain[%0d]: valid=%b meta=%h expected 1/%h", j, bus.out_valid, bus.out_meta, 16'h0200 + 16'(j)); end
            step();
        end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_lost17: out_valid %b expected 0", bus.out_valid); end
        tests_run++; if (overflow_error !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", overflow_error); end
    endtask

    task automatic test_full_read_write();
        do_clear();
        drop_on_false = 1'b0;
        bus.out_ready = 1'b0;
        issue_run(16'h0300, 17);
        step();
        bus.out_ready = 1'b1;
        tests_run++; if (bus.out_meta !== 16'h0300) begin tests_failed++; $display("FAIL frw_head: meta=%h expected 0300", bus.out_meta); end
        step();
        bus.out_ready = 1'b0;
        tests_run++; if (overflow_error !== 1'b0) begin tests_failed++; $display("FAIL frw_no_overflow: got %b expected 0", overflow_error); end
        tests_run++; if (passed_count !== 32'd17) begin tests_failed++; $display("FAIL frw_passed: got %0d expected 17", passed_count); end
        step();
        bus.out_ready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tests_run++; if (bus.out_valid !== 1'b1 || bus.out_meta !== 16'h0300 + 16'(j)) begin tests_failed++; $display("FAIL frw_drain[%0d]: valid=%b meta=%h expected 1/%h", j, bus.out_valid, bus.out_meta, 16'h0300 + 16'(j)); end
            step();
        end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL frw_count16: out_valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_clear_midstream();
        logic seen;
        prep_midstream(16'h0400);
        tests_run++; if (passed_count !== 32'd5 || dropped_count !== 32'd1 || bus.out_meta !== 16'h0401) begin tests_failed++; $display("FAIL clr_pre: passed=%0d dropped=%0d meta=%h expected 5/1/0401", passed_count, dropped_count, bus.out_meta); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_valid: got %b expected 0", bus.out_valid); end
        tests_run++; if (passed_count !== 32'd0 || dropped_count !== 32'd0) begin tests_failed++; $display("FAIL clr_counters: passed=%0d dropped=%0d expected 0/0", passed_count, dropped_count); end
        seen = 1'b0;
        repeat (6) begin step(); if (bus.out_valid) seen = 1'b1; end
        tests_run++; if (seen !== 1'b0 || passed_count !== 32'd0) begin tests_failed++; $display("FAIL clr_inflight: seen=%b passed=%0d expected 0/0", seen, passed_count); end
    endtask

    task automatic test_reset_midstream();
        logic seen;
        prep_midstream(16'h0500);
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_meta !== 16'h0501) begin tests_failed++; $display("FAIL rst_pre: valid=%b meta=%h expected 1/0501", bus.out_valid, bus.out_meta); end
        ap_rst_n = 1'b0;
        step();
        tests_run++; if (bus.out_valid !== 1'b0 || bus.out_flag !== 1'b1 || bus.out_meta !== 16'h0) begin tests_failed++; $display("FAIL rst_out: valid=%b flag=%b meta=%h expected 0/1/0000", bus.out_valid, bus.out_flag, bus.out_meta); end
        tests_run++; if (passed_count !== 32'd0 || dropped_count !== 32'd0) begin tests_failed++; $display("FAIL rst_counters: passed=%0d dropped=%0d expected 0/0", passed_count, dropped_count); end
        ap_rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin step(); if (bus.out_valid) seen = 1'b1; end
        tests_run++; if (seen !== 1'b0 || passed_count !== 32'd0) begin tests_failed++; $display("FAIL rst_inflight: seen=%b passed=%0d expected 0/0", seen, passed_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back_drop();
        test_almost_full();
        test_overflow();
        test_full_read_write();
        test_clear_midstream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
